// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: receive-side UART controller.
//
// Oversamples the line at 16x (runtime divider), validates the start bit at
// mid-bit, samples an 8N1 frame LSB-first at bit centres, checks the stop bit
// and queues accepted bytes in a small FIFO with a valid/ready consumer side.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   rxd       raw asynchronous serial input, idle high
//   baud_div  clk cycles per oversample tick (0 behaves as 1)
//   rx_data   FIFO head byte
//   rx_valid  FIFO non-empty
//   rx_ready  consumer pops the head when rx_valid & rx_ready
//   frame_err sticky: a stop bit was sampled low
//   overrun   sticky: a byte was dropped because the FIFO was full
//   clr_err   clears frame_err and overrun (a same-cycle set wins)
//   busy      receiver FSM is not idle
module uart_rx_sequencer #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  input  logic [DIV_W-1:0] baud_div,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err,
  output logic             busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer (both flops reset to the idle level)
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Oversample tick generator
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_lim_q, div_lim_d;
  logic [DIV_W-1:0] div_lim_new;
  logic             tick;
  logic             start_evt;

  assign div_lim_new = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick        = (div_cnt_q == div_lim_q);

  // The terminal count is only reloaded when the counter wraps (or restarts),
  // so a divider change never lands in the middle of a tick period.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    div_lim_d = div_lim_q;
    if (start_evt || tick) begin
      div_cnt_d = '0;
      div_lim_d = div_lim_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      div_lim_q <= div_lim_new;
    end else begin
      div_cnt_q <= div_cnt_d;
      div_lim_q <= div_lim_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] os_cnt_q, os_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       push_req;
  logic       ferr_set;

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    start_evt = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d   = StStart;
          os_cnt_d  = '0;
          start_evt = 1'b1;
        end
      end

      // Validate at the middle of the start bit; a short low glitch is dropped.
      StStart: begin
        if (tick) begin
          if (os_cnt_q == 4'd7) begin
            os_cnt_d = '0;
            if (!rx_s_q) begin
              state_d   = StData;
              bit_idx_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end

      StData: begin
        if (tick) begin
          if (os_cnt_q == 4'd15) begin
            shreg_d   = {rx_s_q, shreg_q[7:1]};
            os_cnt_d  = '0;
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = StStop;
            end
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end

      StStop: begin
        if (tick) begin
          if (os_cnt_q == 4'd15) begin
            state_d  = StIdle;
            os_cnt_d = '0;
            if (rx_s_q) begin
              push_req = 1'b1;
            end else begin
              ferr_set = 1'b1;
            end
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  assign busy = (state_q != StIdle);

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            full;
  logic            pop;
  logic            do_push;
  logic            ovr_set;

  assign rx_valid = (cnt_q != '0);
  assign full     = (cnt_q == CntW'(FIFO_DEPTH));
  assign pop      = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign do_push  = push_req & (~full | pop);
  assign ovr_set  = push_req & full & ~pop;
  assign rx_data  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags (set beats clear)
  // ---------------------------------------------------------------------------
  logic frame_err_q, overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_set | (frame_err_q & ~clr_err);
      overrun_q   <= ovr_set | (overrun_q & ~clr_err);
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
